mdu_iter: RTL and testbench

Iterative RV32M multiply/divide unit between the operand-read stage and register-file writeback. It takes rs1/rs2 read data plus destination address through a valid/ready handshake and runs radix-2 shift-add multiply or restoring divide, one bit per cycle. It returns one result per operation through a second handshake as a one-cycle register write (wen/waddr/wdata). Division by zero and signed overflow are handled on a one-cycle fast path.

---
 rtl/mdu_iter_if.sv | 32 +++
 rtl/mdu_iter.sv | 158 +++++++++++++++
 tb/tb_mdu_iter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/mdu_iter_if.sv
// mdu_iter_if: handshake/bus bundle for the iterative multiply/divide unit.
//   in_valid/in_ready  : operation offer / accept (funct3, rs1_data, rs2_data, rd_addr)
//   out_valid/out_ready: result offer / writeback slot (wen, waddr, wdata)
//   busy               : unit is working on or holding an operation
// master = operand-read/writeback side, slave = the unit itself.
interface mdu_iter_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
);
   logic                  in_valid;
   logic                  in_ready;
   logic [2:0]            funct3;
   logic [DATA_WIDTH-1:0] rs1_data;
   logic [DATA_WIDTH-1:0] rs2_data;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  out_valid;
   logic                  out_ready;
   logic                  wen;
   logic [ADDR_WIDTH-1:0] waddr;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  busy;

   modport master (
      output in_valid, funct3, rs1_data, rs2_data, rd_addr, out_ready,
      input  in_ready, out_valid, wen, waddr, wdata, busy
   );

   modport slave (
      input  in_valid, funct3, rs1_data, rs2_data, rd_addr, out_ready,
      output in_ready, out_valid, wen, waddr, wdata, busy
   );
endinterface

// File: rtl/mdu_iter.sv
// mdu_iter: iterative RV32M multiply/divide unit, one bit per cycle.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mdu_iter_if.slave (operand handshake in, register-write handshake out)
// Multiply is radix-2 shift-add on operand magnitudes, divide is restoring
// division on magnitudes; signs are fixed up in FIX. Divide-by-zero and
// signed overflow bypass the iteration and complete one cycle after accept.
//
// state | meaning
// IDLE  | waiting for an operation, in_ready high
// CALC  | one multiply/divide step per cycle, DATA_WIDTH steps
// FIX   | sign correction and result select into wdata
// DONE  | result held on wdata/waddr until out_ready
module mdu_iter #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5
) (
   input logic      clk,
   input logic      rst,
   mdu_iter_if.slave bus
);
   localparam int W  = DATA_WIDTH;
   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [W-1:0]   ONE_W  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [2*W-1:0] ONE_2W = {{(2*W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]   MIN_W  = {1'b1, {(W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic [2:0]    op;
   logic          neg_a, neg_b;
   // acc_hi: product high half / partial remainder
   // acc_lo: multiplier being shifted out / dividend shifting out, quotient shifting in
   logic [W-1:0]  acc_hi, acc_lo, opb;

   logic          in_sgn_a, in_sgn_b, in_neg_a, in_neg_b;
   logic [W-1:0]  abs_a, abs_b;
   logic          div_zero, div_ovf;
   logic [W-1:0]  special_res;

   logic [W:0]    mul_sum;
   logic [W:0]    div_shift, div_diff;
   logic          div_ok;

   logic [2*W-1:0] prod, prod_fix;
   logic [W-1:0]   quot_fix, rem_fix, result;

   always_comb begin
      in_sgn_a = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b010) ||
                 (bus.funct3 == 3'b100) || (bus.funct3 == 3'b110);
      in_sgn_b = (bus.funct3 == 3'b001) || (bus.funct3 == 3'b100) ||
                 (bus.funct3 == 3'b110);
      in_neg_a = in_sgn_a & bus.rs1_data[W-1];
      in_neg_b = in_sgn_b & bus.rs2_data[W-1];
      abs_a    = in_neg_a ? (~bus.rs1_data + ONE_W) : bus.rs1_data;
      abs_b    = in_neg_b ? (~bus.rs2_data + ONE_W) : bus.rs2_data;

      div_zero = bus.funct3[2] & (bus.rs2_data == '0);
      // only DIV/REM (funct3[0] = 0) can overflow
      div_ovf  = bus.funct3[2] & ~bus.funct3[0] &
                 (bus.rs1_data == MIN_W) & (bus.rs2_data == '1);
      special_res = '0;
      if (div_zero)
         special_res = bus.funct3[1] ? bus.rs1_data : '1;
      else if (div_ovf)
         special_res = bus.funct3[1] ? '0 : bus.rs1_data;
   end

   always_comb begin
      mul_sum   = {1'b0, acc_hi} + ({1'b0, opb} & {(W+1){acc_lo[0]}});
      div_shift = {acc_hi, acc_lo[W-1]};
      div_diff  = div_shift - {1'b0, opb};
      // remainder < divisor keeps the difference within W+1 bits, so the top bit is the sign
      div_ok    = ~div_diff[W];
   end

   always_comb begin
      prod     = {acc_hi, acc_lo};
      prod_fix = (neg_a ^ neg_b) ? (~prod + ONE_2W) : prod;
      quot_fix = (neg_a ^ neg_b) ? (~acc_lo + ONE_W) : acc_lo;
      rem_fix  = neg_a ? (~acc_hi + ONE_W) : acc_hi;
      case (op)
         3'b000:                  result = prod_fix[W-1:0];
         3'b001, 3'b010, 3'b011:  result = prod_fix[2*W-1:W];
         3'b100, 3'b101:          result = quot_fix;
         default:                 result = rem_fix;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         cnt           <= '0;
         op            <= '0;
         neg_a         <= 1'b0;
         neg_b         <= 1'b0;
         acc_hi        <= '0;
         acc_lo        <= '0;
         opb           <= '0;
         bus.out_valid <= 1'b0;
         bus.wdata     <= '0;
         bus.waddr     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  op        <= bus.funct3;
                  bus.waddr <= bus.rd_addr;
                  neg_a     <= in_neg_a;
                  neg_b     <= in_neg_b;
                  acc_hi    <= '0;
                  acc_lo    <= abs_a;
                  opb       <= abs_b;
                  cnt       <= CW'(W-1);
                  if (div_zero || div_ovf) begin
                     bus.wdata     <= special_res;
                     bus.out_valid <= 1'b1;
                     state         <= DONE;
                  end else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               if (op[2]) begin
                  acc_hi <= div_ok ? div_diff[W-1:0] : div_shift[W-1:0];
                  acc_lo <= {acc_lo[W-2:0], div_ok};
               end else begin
                  acc_hi <= mul_sum[W:1];
                  acc_lo <= {mul_sum[0], acc_lo[W-1:1]};
               end
               if (cnt == '0)
                  state <= FIX;
               else
                  cnt <= cnt - 1'b1;
            end
            FIX: begin
               bus.wdata     <= result;
               bus.out_valid <= 1'b1;
               state         <= DONE;
            end
            DONE: begin
               if (bus.out_ready) begin
                  bus.out_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.in_ready = (state == IDLE);
   assign bus.busy     = (state != IDLE);
   assign bus.wen      = bus.out_valid & bus.out_ready & (bus.waddr != '0);

endmodule

// File: tb/tb_mdu_iter.sv
module tb_mdu_iter;
   localparam int DW = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   total  = 0;

   always #5 clk = ~clk;

   mdu_iter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mdu_iter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // Called at posedge+1 with in_ready high; returns at posedge+1 after the accept edge.
   task automatic accept(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd);
      bus.in_valid = 1'b1;
      bus.funct3   = f;
      bus.rs1_data = a;
      bus.rs2_data = b;
      bus.rd_addr  = rd;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      bus.rs1_data = 32'hDEAD_BEEF;
      bus.rs2_data = 32'h0BAD_F00D;
   endtask

   // Cycles after the accept cycle until out_valid is seen (100 = timed out).
   task automatic wait_valid(output int lat);
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL reset in_ready got %b exp 1", bus.in_ready); else passed++;
      total++; if (bus.busy !== 1'b0) $display("FAIL reset busy got %b exp 0", bus.busy); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL reset out_valid got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.wen !== 1'b0) $display("FAIL reset wen got %b exp 0", bus.wen); else passed++;
      total++; if (bus.wdata !== 32'h0) $display("FAIL reset wdata got %h exp 0", bus.wdata); else passed++;
      total++; if (bus.waddr !== 5'h0) $display("FAIL reset waddr got %h exp 0", bus.waddr); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic test_mul;
      int lat;
      accept(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
      wait_valid(lat);
      total++; if (lat !== 34) $display("FAIL mul latency got %0d exp 34", lat); else passed++;
      total++; if (bus.wdata !== 32'hFFFF_FFEB) $display("FAIL mul wdata got %h exp ffffffeb", bus.wdata); else passed++;
      total++; if (bus.waddr !== 5'd5) $display("FAIL mul waddr got %0d exp 5", bus.waddr); else passed++;
      total++; if (bus.wen !== 1'b1) $display("FAIL mul wen got %b exp 1", bus.wen); else passed++;
      @(posedge clk); #1;
      total++; if (bus.wen !== 1'b0) $display("FAIL mul wen_after got %b exp 0", bus.wen); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL mul out_valid_after got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL mul in_ready_after got %b exp 1", bus.in_ready); else passed++;
   endtask

   task automatic test_mul_high;
      logic [2:0]  f[3]   = '{3'b001, 3'b011, 3'b010};
      logic [31:0] a[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] b[3]   = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp[3] = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
      int lat;
      for (int i = 0; i < 3; i++) begin
         accept(f[i], a[i], b[i], 5'd7);
         wait_valid(lat);
         total++; if (lat !== 34) $display("FAIL mulh[%0d] latency got %0d exp 34", i, lat); else passed++;
         total++; if (bus.wdata !== exp[i]) $display("FAIL mulh[%0d] wdata got %h exp %h", i, bus.wdata, exp[i]); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_div;
      logic [2:0]  f[4]   = '{3'b100, 3'b110, 3'b101, 3'b111};
      logic [31:0] a[4]   = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100};
      logic [31:0] b[4]   = '{32'd2, 32'd2, 32'd2, 32'd7};
      logic [31:0] exp[4] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h7FFF_FFFC, 32'd2};
      int lat;
      for (int i = 0; i < 4; i++) begin
         accept(f[i], a[i], b[i], 5'd12);
         wait_valid(lat);
         total++; if (lat !== 34) $display("FAIL div[%0d] latency got %0d exp 34", i, lat); else passed++;
         total++; if (bus.wdata !== exp[i]) $display("FAIL div[%0d] wdata got %h exp %h", i, bus.wdata, exp[i]); else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_special;
      logic [2:0]  f[5]   = '{3'b101, 3'b110, 3'b100, 3'b100, 3'b110};
      logic [31:0] a[5]   = '{32'd5, 32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
      logic [31:0] b[5]   = '{32'd0, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      logic [31:0] exp[5] = '{32'hFFFF_FFFF, 32'd5, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0};
      int lat;
      for (int i = 0; i < 5; i++) begin
         accept(f[i], a[i], b[i], 5'd3);
         wait_valid(lat);
         total++; if (lat !== 1) $display("FAIL special[%0d] latency got %0d exp 1", i, lat); else passed++;
         total++; if (bus.wdata !== exp[i]) $display("FAIL special[%0d] wdata got %h exp %h", i, bus.wdata, exp[i]); else passed++;
         @(posedge clk); #1;
         total++; if (bus.in_ready !== 1'b1) $display("FAIL special[%0d] in_ready got %b exp 1", i, bus.in_ready); else passed++;
      end
   endtask

   task automatic test_backpressure;
      int lat;
      bus.out_ready = 1'b0;
      accept(3'b000, 32'h1234, 32'h10, 5'd9);
      wait_valid(lat);
      total++; if (lat !== 34) $display("FAIL bp latency got %0d exp 34", lat); else passed++;
      // offer a competing op while stalled; it must be ignored
      bus.in_valid = 1'b1;
      bus.funct3   = 3'b100;
      bus.rs1_data = 32'h55;
      bus.rs2_data = 32'h0;
      bus.rd_addr  = 5'd2;
      for (int i = 0; i < 5; i++) begin
         total++; if (bus.wdata !== 32'h12340) $display("FAIL bp[%0d] wdata got %h exp 00012340", i, bus.wdata); else passed++;
         total++; if (bus.waddr !== 5'd9) $display("FAIL bp[%0d] waddr got %0d exp 9", i, bus.waddr); else passed++;
         total++; if (bus.in_ready !== 1'b0) $display("FAIL bp[%0d] in_ready got %b exp 0", i, bus.in_ready); else passed++;
         total++; if (bus.wen !== 1'b0) $display("FAIL bp[%0d] wen got %b exp 0", i, bus.wen); else passed++;
         total++; if (bus.out_valid !== 1'b1) $display("FAIL bp[%0d] out_valid got %b exp 1", i, bus.out_valid); else passed++;
         @(posedge clk); #1;
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.wen !== 1'b1) $display("FAIL bp release wen got %b exp 1", bus.wen); else passed++;
      @(posedge clk); #1;
      total++; if (bus.wen !== 1'b0) $display("FAIL bp after wen got %b exp 0", bus.wen); else passed++;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL bp after out_valid got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL bp after in_ready got %b exp 1", bus.in_ready); else passed++;

      bus.out_ready = 1'b0;
      accept(3'b011, 32'd2, 32'd3, 5'd0);
      wait_valid(lat);
      total++; if (lat !== 34) $display("FAIL rd0 latency got %0d exp 34", lat); else passed++;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      #1;
      total++; if (bus.wen !== 1'b0) $display("FAIL rd0 wen got %b exp 0", bus.wen); else passed++;
      total++; if (bus.out_valid !== 1'b1) $display("FAIL rd0 out_valid got %b exp 1", bus.out_valid); else passed++;
      @(posedge clk); #1;
      total++; if (bus.out_valid !== 1'b0) $display("FAIL rd0 after out_valid got %b exp 0", bus.out_valid); else passed++;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL rd0 after in_ready got %b exp 1", bus.in_ready); else passed++;
   endtask

   task automatic test_reset_abort;
      int lat;
      int viol = 0;
      accept(3'b100, 32'd100, 32'd7, 5'd4);
      repeat (10) begin
         @(posedge clk); #1;
      end
      total++; if (bus.busy !== 1'b1) $display("FAIL abort busy_before got %b exp 1", bus.busy); else passed++;
      rst = 1'b1;
      #1;
      total++; if (bus.busy !== 1'b0) $display("FAIL abort busy got %b exp 0", bus.busy); else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      total++; if (bus.in_ready !== 1'b1) $display("FAIL abort in_ready got %b exp 1", bus.in_ready); else passed++;
      repeat (40) begin
         if (bus.out_valid || bus.wen) viol++;
         @(posedge clk); #1;
      end
      total++; if (viol !== 0) $display("FAIL abort out_valid_or_wen got %0d cycles exp 0", viol); else passed++;
      accept(3'b000, 32'd3, 32'd4, 5'd1);
      wait_valid(lat);
      total++; if (lat !== 34) $display("FAIL post_reset latency got %0d exp 34", lat); else passed++;
      total++; if (bus.wdata !== 32'd12) $display("FAIL post_reset wdata got %h exp 0000000c", bus.wdata); else passed++;
      total++; if (bus.wen !== 1'b1) $display("FAIL post_reset wen got %b exp 1", bus.wen); else passed++;
      @(posedge clk); #1;
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.funct3    = 3'b000;
      bus.rs1_data  = '0;
      bus.rs2_data  = '0;
      bus.rd_addr   = '0;
      bus.out_ready = 1'b1;
      test_reset();
      test_mul();
      test_mul_high();
      test_div();
      test_special();
      test_backpressure();
      test_reset_abort();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout exp completion");
      $fatal(1, "watchdog");
   end

endmodule
